// File: rtl/slingshot_ctrl.sv
// slingshot_ctrl: per-triangle hit detect, kick/score pulse, flash and cooldown sequencer.
// Optional saturating hit counter when SLINGSHOT_HIT_COUNT_EN is defined.
module slingshot_ctrl #(
  parameter int ORIENTATION = 0,
  parameter int FLASH_FRAMES = 8,
  parameter int COOLDOWN_FRAMES = 16,
  parameter logic [7:0] SCORE_VALUE = 8'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       triangleDraw,
  input  logic       ballDraw,
  output logic       kick,
  output logic       kickDir,
  output logic       scorePulse,
  output logic [7:0] scoreValue,
  output logic       flash,
  output logic       busy,
  output logic [7:0] hitCount
);
  localparam logic [1:0] IDLE = 2'd0, KICK = 2'd1, FLASH = 2'd2, COOLDOWN = 2'd3;
  localparam logic [7:0] FF = 8'(FLASH_FRAMES), CF = 8'(COOLDOWN_FRAMES);
  logic [1:0] state, state_n;
  logic [7:0] frame_cnt, cnt_n;
  logic hit_seen, hit_now;
  assign hit_now = enable && triangleDraw && ballDraw && state == IDLE;
  assign kickDir = ORIENTATION[0];
  always_comb begin
    state_n = state;
    cnt_n = frame_cnt;
    if (!enable) begin
      state_n = IDLE;
      cnt_n = 8'd0;
    end else case (state)
      IDLE: state_n = (startOfFrame && hit_seen) ? KICK : IDLE;
      KICK: begin
        state_n = FF != 8'd0 ? FLASH : CF != 8'd0 ? COOLDOWN : IDLE;
        cnt_n = FF != 8'd0 ? FF : CF;
      end
      FLASH: if (startOfFrame) begin
        state_n = frame_cnt > 8'd1 ? FLASH : CF != 8'd0 ? COOLDOWN : IDLE;
        cnt_n = frame_cnt > 8'd1 ? frame_cnt - 8'd1 : CF;
      end
      default: if (startOfFrame) begin
        state_n = frame_cnt > 8'd1 ? COOLDOWN : IDLE;
        cnt_n = frame_cnt > 8'd1 ? frame_cnt - 8'd1 : 8'd0;
      end
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      frame_cnt <= 8'd0;
      hit_seen <= 1'b0;
      kick <= 1'b0;
      scorePulse <= 1'b0;
      scoreValue <= 8'd0;
      flash <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      frame_cnt <= cnt_n;
      hit_seen <= enable && (hit_now || (hit_seen && !startOfFrame));
      kick <= state_n == KICK;
      scorePulse <= state_n == KICK;
      scoreValue <= state_n == KICK ? SCORE_VALUE : 8'd0;
      flash <= state_n == FLASH;
      busy <= state_n != IDLE;
    end
  end
`ifdef SLINGSHOT_HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) hitCount <= 8'd0;
    else if (state == KICK && hitCount != 8'hff) hitCount <= hitCount + 8'd1;
  end
`else
  assign hitCount = 8'd0;
`endif
endmodule

// File: tb/tb_slingshot_ctrl.sv
// tb_slingshot_ctrl: frame-level vector table with a scoreboard queue, plus abort and hit-count sequences.
module tb_slingshot_ctrl;
  logic clk = 1'b0, reset = 1'b1, startOfFrame = 1'b0, enable = 1'b0, triangleDraw = 1'b0, ballDraw = 1'b0;
  logic kick, kickDir, scorePulse, flash, busy;
  logic [7:0] scoreValue, hitCount;
  logic kick_z, kdir_z, sp_z, flash_z, busy_z;
  logic [7:0] sv_z, hc_z;
`ifdef SLINGSHOT_HIT_COUNT_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  slingshot_ctrl u_dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .triangleDraw(triangleDraw), .ballDraw(ballDraw), .kick(kick), .kickDir(kickDir),
    .scorePulse(scorePulse), .scoreValue(scoreValue), .flash(flash), .busy(busy), .hitCount(hitCount)
  );
  slingshot_ctrl #(.ORIENTATION(1), .FLASH_FRAMES(0), .COOLDOWN_FRAMES(0)) u_z (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .triangleDraw(triangleDraw), .ballDraw(ballDraw), .kick(kick_z), .kickDir(kdir_z),
    .scorePulse(sp_z), .scoreValue(sv_z), .flash(flash_z), .busy(busy_z), .hitCount(hc_z)
  );
  typedef struct {
    logic hit;
    logic sofhit;
    logic drop;
    int kd;
    int fd;
    int bd;
    int kz;
  } vec_t;
  vec_t vec[$];
  vec_t exp_q[$];
  int checks = 0, failures = 0;
  int kd, fd, bd, kz, pd, sv, fz;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic e, input logic t, input logic b);
    startOfFrame = s;
    enable = e;
    triangleDraw = t;
    ballDraw = b;
    @(posedge clk);
    #1;
    kd += int'(kick);
    fd += int'(flash);
    bd += int'(busy);
    kz += int'(kick_z);
    fz += int'(flash_z);
    pd += int'(scorePulse);
    sv += int'(scoreValue);
  endtask
  task automatic frame(input logic hit, input logic sofhit, input logic drop);
    logic h;
    kd = 0; fd = 0; bd = 0; kz = 0; pd = 0; sv = 0; fz = 0;
    for (int c = 0; c < 8; c++) begin
      h = (c == 0) ? sofhit : (hit && c >= 3 && c <= 5);
      step(c == 0, !(drop && c >= 3), h, h);
      if (drop && c == 2) chk("pre_abort_flash", int'(flash), 1);
      if (drop && c == 3) chk("abort_flash_busy", int'({flash, busy}), 0);
    end
  endtask
  task automatic add(input logic hit, input logic sofhit, input logic drop, input int k, input int f, input int b, input int z);
    vec_t v;
    v.hit = hit; v.sofhit = sofhit; v.drop = drop; v.kd = k; v.fd = f; v.bd = b; v.kz = z;
    vec.push_back(v);
  endtask
  initial begin
    vec_t v;
    int zk_model = 0, zk_loop = 0;
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 7, 8, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 8, 8, 0);
    add(0, 0, 0, 0, 0, 8, 0);
    for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 0, 8, i == 0 ? 0 : 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 7, 8, 1);
    add(0, 0, 0, 0, 8, 8, 0);
    add(0, 0, 0, 0, 8, 8, 0);
    add(0, 0, 1, 0, 3, 3, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 7, 8, 1);
    for (int c = 0; c < 3; c++) step(c[0], 1'b1, 1'b1, 1'b1);
    chk("reset_outputs", int'({kick, scorePulse, scoreValue, flash, busy, hitCount}), 0);
    chk("reset_outputs_z", int'({kick_z, sp_z, sv_z, flash_z, busy_z, hc_z}), 0);
    chk("kickdir", int'(kickDir), 0);
    chk("kickdir_z", int'(kdir_z), 1);
    reset = 1'b0;
    for (int i = 0; i < vec.size(); i++) begin
      exp_q.push_back(vec[i]);
      zk_model += vec[i].kz;
      frame(vec[i].hit, vec[i].sofhit, vec[i].drop);
      v = exp_q.pop_front();
      chk($sformatf("row%0d_kick", i), kd, v.kd);
      chk($sformatf("row%0d_pulse", i), pd, v.kd);
      chk($sformatf("row%0d_score", i), sv, 10 * v.kd);
      chk($sformatf("row%0d_flash", i), fd, v.fd);
      chk($sformatf("row%0d_busy", i), bd, v.bd);
      chk($sformatf("row%0d_kick_z", i), kz, v.kz);
      chk($sformatf("row%0d_flash_z", i), fz, 0);
    end
    chk("hitcount_after_table", int'(hitCount), HC_EN ? 3 : 0);
    chk("hitcount_z_after_table", int'(hc_z), HC_EN ? zk_model : 0);
    for (int i = 0; i < 261; i++) begin
      frame(i < 260, 1'b0, 1'b0);
      zk_loop += kz;
    end
    chk("hit_frames_kicks_z", zk_loop, 260);
    chk("hitcount_z_saturated", int'(hc_z), HC_EN ? 255 : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
